regfile_wr_ctrl: RTL and testbench
==================================

# regfile_wr_ctrl

Write-port controller for the 32 x 64-bit register file. Sequences the post-reset register initialisation (X_i = i, X31 untouched) and then shares the single write port (`we3`/`wa3`/`wd3`) between two writeback requesters, A (execute/ALU) and B (memory/load), with round-robin arbitration. It sits between the writeback stages and the register file. It drives the register file's write port through registered outputs only.

## Interface
- `W`, 64, data width
- `AW`, 5, register address width
- `NREG`, 32, register count; index NREG-1 (31) is XZR

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = in reset)
- `req_a` / `req_b`  in  1  write request from requester A / B
- `addr_a` / `addr_b`  in  AW  destination register
- `data_a` / `data_b`  in  W  write data
- `gnt_a` / `gnt_b`  out  1  one-cycle grant pulse, registered
- `we3`  out  1  register file write enable, registered
- `wa3`  out  AW  register file write address, registered
- `wd3`  out  W  register file write data, registered
- `init_done`  out  1  high once initialisation is complete

## Operation
- **Reset values:** all outputs 0. FSM is in ST_INIT when `REGFILE_INIT_EN` is defined, otherwise ST_ARB. Init index is 0. The round-robin pointer favours A.
- **ST_INIT:**
  - Each edge loads `we3`=1, `wa3`=idx, `wd3`=idx zero-extended to W, then increments idx.
  - The edge that loads idx 30 also sets `init_done`=1 and moves the FSM to ST_ARB. Index 31 is never written.
  - No grants are issued in ST_INIT. Pending requests are held by their requesters, not dropped.
- **ST_ARB, on each edge:**
  - If exactly one `req_x` is high, grant x.
  - If both are high, grant the requester not granted last. The pointer updates on every grant.
  - A grant loads `wa3`=`addr_x`, `wd3`=`data_x`, `gnt_x`=1.
  - `we3`=1, except `we3`=0 when `addr_x`==31: the write is discarded, but the grant still pulses.
  - With no request: `we3`=0, both grants 0, `wa3`/`wd3` hold their previous values.
- **Requester contract:**
  - `addr_x`/`data_x` stay stable while `req_x` is high and not yet granted.
  - In the cycle `gnt_x` is high, the requester either drops `req_x` or presents the next transaction. A `req_x` sampled at that cycle's end is a new request, which allows back-to-back writes.
- **Invariants:**
  - `gnt_a` and `gnt_b` are never high together.
  - `init_done` stays 1 until reset.

## Timing
- **Latency:** `req_x` sampled at edge N gives `gnt_x`/`we3`/`wa3`/`wd3` valid in cycle N+1. The register file commits at edge N+1.
- **Throughput:** one write per cycle. Under continuous dual requests, each requester gets one write every 2 cycles.
- **Init:** 31 cycles after reset release. `init_done` is high from the 31st post-release cycle, together with the X30 write.
- **Reset asserted mid-operation:** all outputs clear immediately (asynchronously). An in-flight grant is lost, and INIT restarts after release.
- **Simultaneous events:**
  - A request arriving on the INIT→ARB transition edge is not granted on that edge; it is granted on the next one.
  - Both requesters targeting the same register are serialised, so the later grant wins in the register file.

## Configuration
- **`REGFILE_INIT_EN` defined:** ST_INIT sequence as above. `init_done` rises after 31 cycles.
- **Not defined:**
  - No init logic and no index counter; the FSM resets directly into ST_ARB.
  - `init_done` is tied to 1, but its reset value is still 0 while `reset`=0.
  - The first grant can occur on the first edge after release.

## Structure
- **Package `regfile_pkg`:**
  - state enum `regfile_wr_state_t` {ST_INIT, ST_ARB}
  - `XZR_IDX` = 31
  - `REG_W` = 64, `REG_AW` = 5, `NREG` = 32
- **Sub-module `rr_arbiter2`:**
  - two-input round-robin arbiter, with the last-grant pointer kept inside it
  - pure request→one-hot grant logic plus the pointer register
  - instantiated once by `regfile_wr_ctrl`

## Test plan
- **Init (`REGFILE_INIT_EN` defined):** release reset → for 31 consecutive cycles `we3`=1 and `wa3`=`wd3`=0,1,…,30; `init_done`=1 in the last of those cycles; `wa3` never 31; no grants.
- **Single request:** after init, `req_a`=1, `addr_a`=5, `data_a`=0xDEAD for one cycle → next cycle `gnt_a`=1, `we3`=1, `wa3`=5, `wd3`=0xDEAD; following cycle `we3`=0.
- **Contention:** hold `req_a`=`req_b`=1 continuously (A addr 1, B addr 2) → grants alternate A,B,A,B starting with A; `wa3` alternates 1,2; never both grants high.
- **XZR write:** `req_b`=1, `addr_b`=31, `data_b`=0xFF → `gnt_b` pulses, `we3`=0 in that cycle.
- **Request during INIT:** assert `req_a` (addr 7) in init cycle 10 and hold → no grant until ST_ARB; granted on the first ARB edge after the transition edge, with `wa3`=7.
- **Reset mid-stream:** drive `reset`=0 during contention → all outputs 0 within the same cycle; after release INIT restarts from idx 0 and the pointer favours A.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port controller.
package regfile_pkg;

   localparam int REG_W   = 64;
   localparam int REG_AW  = 5;
   localparam int NREG    = 32;
   localparam int XZR_IDX = 31;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_ARB  = 1'b1
   } regfile_wr_state_t;

endpackage

// File: rtl/regfile_wr_ctrl_arb.sv
// Two-input round-robin arbiter: combinational one-hot grant plus the
// last-grant pointer register.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic prefer_b;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (en) begin
         if (req_a && req_b) begin
            gnt_a = !prefer_b;
            gnt_b = prefer_b;
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

   // Whoever just won yields priority to the other side next time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prefer_b <= 1'b0;
      end else if (gnt_a) begin
         prefer_b <= 1'b1;
      end else if (gnt_b) begin
         prefer_b <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32 x 64 register file: optional post-reset
// init sequence (enabled by REGFILE_INIT_EN) then round-robin writeback.
module regfile_wr_ctrl
   import regfile_pkg::*;
#(
   parameter int W    = REG_W,
   parameter int AW   = REG_AW,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_a,
   input  logic          req_b,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   input  logic [W-1:0]  data_a,
   input  logic [W-1:0]  data_b,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [W-1:0]  wd3,
   output logic          init_done
);

   localparam logic [AW-1:0] XZR_ADDR = AW'(NREG - 1);

   logic          arb_en;
   logic          grant_a;
   logic          grant_b;
   logic          we_n;
   logic [AW-1:0] wa_n;
   logic [W-1:0]  wd_n;

`ifdef REGFILE_INIT_EN
   localparam logic [AW-1:0] INIT_LAST = AW'(NREG - 2);

   regfile_wr_state_t state;
   logic [AW-1:0]     idx;

   assign arb_en = (state == ST_ARB);

   // Walk idx 0..NREG-2, leaving the zero register untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_INIT;
         idx       <= '0;
         init_done <= 1'b0;
      end else if (state == ST_INIT) begin
         idx <= idx + 1'b1;
         if (idx == INIT_LAST) begin
            state     <= ST_ARB;
            init_done <= 1'b1;
         end
      end
   end
`else
   assign arb_en = 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b1;
      end
   end
`endif

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .req_a (req_a),
      .req_b (req_b),
      .gnt_a (grant_a),
      .gnt_b (grant_b)
   );

   // Writes to the zero register are granted but never enabled.
   always_comb begin
      we_n = 1'b0;
      wa_n = wa3;
      wd_n = wd3;
      if (grant_a) begin
         we_n = (addr_a != XZR_ADDR);
         wa_n = addr_a;
         wd_n = data_a;
      end else if (grant_b) begin
         we_n = (addr_b != XZR_ADDR);
         wa_n = addr_b;
         wd_n = data_b;
      end
`ifdef REGFILE_INIT_EN
      if (state == ST_INIT) begin
         we_n = 1'b1;
         wa_n = idx;
         wd_n = W'(idx);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         we3   <= 1'b0;
         wa3   <= '0;
         wd3   <= '0;
      end else begin
         gnt_a <= grant_a;
         gnt_b <= grant_b;
         we3   <= we_n;
         wa3   <= wa_n;
         wd3   <= wd_n;
      end
   end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed scoreboard bench for regfile_wr_ctrl; covers the init sequence
// when REGFILE_INIT_EN is defined, otherwise the direct-to-arbitration build.
module tb_regfile_wr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b;
   logic [4:0]  addr_a, addr_b;
   logic [63:0] data_a, data_b;
   logic        gnt_a, gnt_b, we3, init_done;
   logic [4:0]  wa3;
   logic [63:0] wd3;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic        ga;
      logic        gb;
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic        id;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   regfile_wr_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_a     (req_a),
      .req_b     (req_b),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .data_a    (data_a),
      .data_b    (data_b),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .init_done (init_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic ga, input logic gb, input logic we,
                           input logic [4:0] wa, input logic [63:0] wd, input logic id);
      exp_t e;
      e.tag = tag;
      e.ga  = ga;
      e.gb  = gb;
      e.we  = we;
      e.wa  = wa;
      e.wd  = wd;
      e.id  = id;
      sb.push_back(e);
   endtask

   task automatic check_output();
      exp_t        e;
      logic [72:0] obs;
      logic [72:0] expv;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("[TB] FAIL scoreboard_empty: observed no expected entry, required one");
         return;
      end
      e    = sb.pop_front();
      obs  = {gnt_a, gnt_b, we3, wa3, wd3, init_done};
      expv = {e.ga, e.gb, e.we, e.wa, e.wd, e.id};
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed gnt_a=%b gnt_b=%b we3=%b wa3=%0d wd3=%h init_done=%b, expected gnt_a=%b gnt_b=%b we3=%b wa3=%0d wd3=%h init_done=%b",
                e.tag, gnt_a, gnt_b, we3, wa3, wd3, init_done, e.ga, e.gb, e.we, e.wa, e.wd, e.id);
      end
   endtask

   task automatic apply_stimulus(input string tag, input logic ga, input logic gb, input logic we,
                                 input logic [4:0] wa, input logic [63:0] wd, input logic id);
      push_exp(tag, ga, gb, we, wa, wd, id);
      tick();
      check_output();
   endtask

   task automatic check_now(input string tag, input logic ga, input logic gb, input logic we,
                            input logic [4:0] wa, input logic [63:0] wd, input logic id);
      push_exp(tag, ga, gb, we, wa, wd, id);
      check_output();
   endtask

   initial begin
      reset  = 1'b0;
      req_a  = 1'b0;
      req_b  = 1'b0;
      addr_a = '0;
      addr_b = '0;
      data_a = '0;
      data_b = '0;

      tick();
      check_now("reset_state", 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);

`ifdef REGFILE_INIT_EN
      reset = 1'b1;
      for (int i = 0; i < 31; i++) begin
         if (i == 10) begin
            req_a  = 1'b1;
            addr_a = 5'd7;
            data_a = 64'h77;
         end
         apply_stimulus("init_write", 1'b0, 1'b0, 1'b1, 5'(i), 64'(i), (i == 30));
      end
`else
      reset  = 1'b1;
      req_a  = 1'b1;
      addr_a = 5'd7;
      data_a = 64'h77;
`endif
      apply_stimulus("first_arb_grant", 1'b1, 1'b0, 1'b1, 5'd7, 64'h77, 1'b1);
      req_a = 1'b0;
      apply_stimulus("idle_hold", 1'b0, 1'b0, 1'b0, 5'd7, 64'h77, 1'b1);

      req_a  = 1'b1;
      addr_a = 5'd5;
      data_a = 64'hDEAD;
      apply_stimulus("single_a", 1'b1, 1'b0, 1'b1, 5'd5, 64'hDEAD, 1'b1);
      req_a = 1'b0;
      apply_stimulus("single_a_after", 1'b0, 1'b0, 1'b0, 5'd5, 64'hDEAD, 1'b1);

      req_b  = 1'b1;
      addr_b = 5'd31;
      data_b = 64'hFF;
      apply_stimulus("xzr_b", 1'b0, 1'b1, 1'b0, 5'd31, 64'hFF, 1'b1);
      req_b = 1'b0;
      apply_stimulus("xzr_idle", 1'b0, 1'b0, 1'b0, 5'd31, 64'hFF, 1'b1);

      req_a  = 1'b1;
      addr_a = 5'd1;
      data_a = 64'hA1;
      req_b  = 1'b1;
      addr_b = 5'd2;
      data_b = 64'hB2;
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0)
            apply_stimulus("contention_a", 1'b1, 1'b0, 1'b1, 5'd1, 64'hA1, 1'b1);
         else
            apply_stimulus("contention_b", 1'b0, 1'b1, 1'b1, 5'd2, 64'hB2, 1'b1);
      end

      // Last grant was A, so a surviving pointer would now favour B.
      reset = 1'b0;
      #1;
      check_now("async_reset", 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
      apply_stimulus("held_in_reset", 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
      reset = 1'b1;

`ifdef REGFILE_INIT_EN
      for (int i = 0; i < 31; i++) begin
         apply_stimulus("reinit_write", 1'b0, 1'b0, 1'b1, 5'(i), 64'(i), (i == 30));
      end
`endif
      apply_stimulus("post_reset_rr_a", 1'b1, 1'b0, 1'b1, 5'd1, 64'hA1, 1'b1);
      apply_stimulus("post_reset_rr_b", 1'b0, 1'b1, 1'b1, 5'd2, 64'hB2, 1'b1);
      req_a = 1'b0;
      req_b = 1'b0;
      apply_stimulus("final_idle", 1'b0, 1'b0, 1'b0, 5'd2, 64'hB2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
